onehot_seg_display: RTL and testbench



---
 rtl/onehot_seg_display.sv | 266 ++++++++++++++++++++++++++
 tb/tb_onehot_seg_display.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_seg_display.sv
// Purpose: one-hot position -> 1-based index -> RADIX digits -> active-low 7-segment buses.
// Latency: load sampled at edge k; hex_out/err updated and busy cleared at edge k+N_DIGITS+2.
// Backpressure: none; load is honoured only while busy=0, otherwise dropped (never queued).
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset (dominates load and any conversion)
//   in_val   one-hot position vector, bit i -> index i+1
//   load     sample in_val (ignored while busy)
//   hex_out  active-low gfedcba segments per digit, [6:0] = least-significant digit
//   busy     conversion in progress
//   err      displayed value is the blinking dash pattern (zero/multi-hot/overflow)
module onehot_seg_display #(
    parameter int N_IN      = 26,
    parameter int N_DIGITS  = 2,
    parameter int RADIX     = 16,
    parameter int BLANK_LZ  = 0,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_IN-1:0]       in_val,
    input  logic                  load,
    output logic [7*N_DIGITS-1:0] hex_out,
    output logic                  busy,
    output logic                  err
);

    localparam int W   = $clog2(N_IN + 1);
    // Four spare bits keep the radix constant representable even for tiny W.
    localparam int VW  = W + 4;
    localparam int DCW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    function automatic logic [63:0] radix_pow();
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < N_DIGITS; i++) begin
            p = p * 64'(RADIX);
        end
        return p;
    endfunction

    localparam logic [63:0]          LIMIT  = radix_pow();
    localparam logic [7*N_DIGITS-1:0] DASHES = {N_DIGITS{7'h3F}};
    localparam logic [7*N_DIGITS-1:0] BLANKS = {N_DIGITS{7'h7F}};

    generate
        if (RADIX != 16 && RADIX != 10) begin : g_bad_radix
            $error("onehot_seg_display: RADIX must be 16 or 10");
        end
        if (N_IN < 2) begin : g_bad_nin
            $error("onehot_seg_display: N_IN must be at least 2");
        end
        if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_ndig
            $error("onehot_seg_display: N_DIGITS must be 1..8");
        end
        if (BLINK_DIV < 1) begin : g_bad_blink
            $error("onehot_seg_display: BLINK_DIV must be at least 1");
        end
    endgenerate

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h18;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENC,
        S_CONV,
        S_UPD
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [N_IN-1:0]         cap;
    logic [W-1:0]            v;
    logic                    ok_r;
    logic                    ovf_r;
    logic [DCW-1:0]          dcnt;
    logic [4*N_DIGITS-1:0]   dig;
    logic [7*N_DIGITS-1:0]   disp;
    logic                    err_r;
    logic [BCW-1:0]          bcnt;
    logic                    phase_on;

    logic [W-1:0]            enc_idx;
    logic                    seen_one;
    logic                    seen_more;
    logic                    enc_ovf;
    logic [VW-1:0]           vx;
    logic [VW-1:0]           q;
    logic [VW-1:0]           r;
    logic [4*N_DIGITS+3:0]   dig_sh;
    logic [4*N_DIGITS-1:0]   dig_next;
    logic [7*N_DIGITS-1:0]   seg_next;
    logic                    lead;

    // ---------------------------------------------------------------
    // Encoder: OR of (i+1) over set bits is exact for one-hot input;
    // seen_more flags a second set bit without a full popcount.
    // ---------------------------------------------------------------
    always_comb begin
        enc_idx   = '0;
        seen_one  = 1'b0;
        seen_more = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (cap[i]) begin
                seen_more = seen_more | seen_one;
                seen_one  = 1'b1;
                enc_idx   = enc_idx | W'(i + 1);
            end
        end
    end

    assign enc_ovf = (64'(enc_idx) >= LIMIT);

    // ---------------------------------------------------------------
    // One digit-extraction step: r = v mod RADIX, q = v / RADIX.
    // ---------------------------------------------------------------
    assign vx = VW'(v);

    generate
        if (RADIX == 16) begin : g_hex
            assign q = vx >> 4;
            assign r = vx & VW'(15);
        end else begin : g_dec
            assign q = vx / VW'(RADIX);
            assign r = vx % VW'(RADIX);
        end
    endgenerate

    // Digits enter at the top and shift down, so after N_DIGITS steps the
    // first (least-significant) digit extracted sits in slot 0.
    assign dig_sh   = {r[3:0], dig};
    assign dig_next = dig_sh[4*N_DIGITS+3:4];

    // ---------------------------------------------------------------
    // Segment mapping with optional leading-zero blanking; slot 0 is
    // always shown so a zero value still displays "0".
    // ---------------------------------------------------------------
    always_comb begin
        seg_next = '0;
        lead     = (BLANK_LZ != 0);
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (lead && (i != 0) && (dig[4*i +: 4] == 4'h0)) begin
                seg_next[7*i +: 7] = 7'h7F;
            end else begin
                lead               = 1'b0;
                seg_next[7*i +: 7] = seg7(dig[4*i +: 4]);
            end
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load) begin
                    state_nxt = S_ENC;
                end
            end
            S_ENC:  state_nxt = S_CONV;
            S_CONV: begin
                if (dcnt == DCW'(N_DIGITS - 1)) begin
                    state_nxt = S_UPD;
                end
            end
            S_UPD:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath. disp/err_r change only in UPD, so an interrupted
    // conversion never leaks a partial value to the display.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cap   <= '0;
            v     <= '0;
            ok_r  <= 1'b0;
            ovf_r <= 1'b0;
            dcnt  <= '0;
            dig   <= '0;
            disp  <= BLANKS;
            err_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        cap <= in_val;
                    end
                end
                S_ENC: begin
                    v     <= enc_idx;
                    ok_r  <= seen_one & ~seen_more;
                    ovf_r <= enc_ovf;
                    dcnt  <= '0;
                end
                S_CONV: begin
                    dig  <= dig_next;
                    v    <= q[W-1:0];
                    dcnt <= dcnt + DCW'(1);
                end
                S_UPD: begin
                    disp  <= seg_next;
                    err_r <= ~ok_r | ovf_r;
                end
                default: ;
            endcase
        end
    end

    // Free-running blink timebase; phase starts "on" out of reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bcnt     <= '0;
            phase_on <= 1'b1;
        end else if (bcnt == BCW'(BLINK_DIV - 1)) begin
            bcnt     <= '0;
            phase_on <= ~phase_on;
        end else begin
            bcnt <= bcnt + BCW'(1);
        end
    end

    assign hex_out = err_r ? (phase_on ? DASHES : BLANKS) : disp;
    assign busy    = (state != S_IDLE);
    assign err     = err_r;

    // Quotient/remainder high bits and the shifted-out nibble are never needed.
    logic unused_bits;
    assign unused_bits = ^{q[VW-1:W], r[VW-1:4], dig_sh[3:0]};

endmodule

// File: tb/tb_onehot_seg_display.sv
module tb_onehot_seg_display;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned n_run = 0;

    // Non-reset edges since the last reset: the blink phase is on while
    // (n_run / 4) is even for the BLINK_DIV=4 instances.
    always @(posedge clk) begin
        if (!reset_n) n_run <= 0;
        else          n_run <= n_run + 1;
    end

    // d: defaults (hex, 2 digits)
    logic [25:0] d_in;  logic d_load;  logic [13:0] d_hex;  logic d_busy, d_err;
    // t: decimal, 2 digits, leading-zero blanking
    logic [25:0] t_in;  logic t_load;  logic [13:0] t_hex;  logic t_busy, t_err;
    // b: hex, fast blink
    logic [25:0] b_in;  logic b_load;  logic [13:0] b_hex;  logic b_busy, b_err;
    // o: decimal, 1 digit, fast blink
    logic [25:0] o_in;  logic o_load;  logic [6:0]  o_hex;  logic o_busy, o_err;

    onehot_seg_display u_d (
        .clk(clk), .reset_n(reset_n), .in_val(d_in), .load(d_load),
        .hex_out(d_hex), .busy(d_busy), .err(d_err)
    );
    onehot_seg_display #(.N_IN(26), .N_DIGITS(2), .RADIX(10), .BLANK_LZ(1)) u_t (
        .clk(clk), .reset_n(reset_n), .in_val(t_in), .load(t_load),
        .hex_out(t_hex), .busy(t_busy), .err(t_err)
    );
    onehot_seg_display #(.N_IN(26), .N_DIGITS(2), .RADIX(16), .BLINK_DIV(4)) u_b (
        .clk(clk), .reset_n(reset_n), .in_val(b_in), .load(b_load),
        .hex_out(b_hex), .busy(b_busy), .err(b_err)
    );
    onehot_seg_display #(.N_IN(26), .N_DIGITS(1), .RADIX(10), .BLINK_DIV(4)) u_o (
        .clk(clk), .reset_n(reset_n), .in_val(o_in), .load(o_load),
        .hex_out(o_hex), .busy(o_busy), .err(o_err)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] dash1();
        return (((n_run / 4) % 2) == 0) ? 7'h3F : 7'h7F;
    endfunction

    function automatic logic [13:0] dash2();
        return {dash1(), dash1()};
    endfunction

    initial begin
        reset_n = 1'b0;
        d_in = '0; d_load = 1'b0;
        t_in = '0; t_load = 1'b0;
        b_in = '0; b_load = 1'b0;
        o_in = '0; o_load = 1'b0;
        tick(2);

        // Reset state
        chk("rst_d_hex", d_hex, 14'h3FFF);
        chk("rst_d_busy", d_busy, 1'b0);
        chk("rst_d_err", d_err, 1'b0);
        chk("rst_b_hex", b_hex, 14'h3FFF);
        chk("rst_o_hex", o_hex, 7'h7F);
        reset_n = 1'b1;
        tick(1);

        // 1: defaults, bit25 -> 0x1A
        d_in = 26'd1 << 25; d_load = 1'b1;
        tick(1);                       // edge k
        d_load = 1'b0;
        chk("t1_busy_k1", d_busy, 1'b1);
        tick(2);                       // edge k+2
        chk("t1_busy_k3", d_busy, 1'b1);
        tick(1);                       // edge k+3
        chk("t1_busy_k4", d_busy, 1'b1);
        chk("t1_no_partial", d_hex, 14'h3FFF);
        tick(1);                       // edge k+4
        chk("t1_hex", d_hex, {7'h79, 7'h08});
        chk("t1_err", d_err, 1'b0);
        chk("t1_busy_done", d_busy, 1'b0);

        // 2: decimal 26 -> "26", then 4 with blanking, then 10 -> "10"
        t_in = 26'd1 << 25; t_load = 1'b1;
        tick(1); t_load = 1'b0; tick(4);
        chk("t2_dec26", t_hex, {7'h24, 7'h02});
        chk("t2_err", t_err, 1'b0);
        t_in = 26'd1 << 3; t_load = 1'b1;
        tick(1); t_load = 1'b0; tick(4);
        chk("t2_blank4", t_hex, {7'h7F, 7'h19});
        t_in = 26'd1 << 9; t_load = 1'b1;
        tick(1); t_load = 1'b0; tick(4);
        chk("t2_dec10", t_hex, {7'h79, 7'h40});

        // 3: zero input -> blinking dashes
        b_in = '0; b_load = 1'b1;
        tick(1); b_load = 1'b0; tick(4);
        chk("t3_zero_err", b_err, 1'b1);
        chk("t3_zero_busy", b_busy, 1'b0);
        chk("t3_zero_hex", b_hex, dash2());
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("t3_blink", b_hex, dash2());
        end
        // multi-hot
        b_in = 26'h24; b_load = 1'b1;
        tick(1); b_load = 1'b0; tick(4);
        chk("t3_multi_err", b_err, 1'b1);
        chk("t3_multi_hex", b_hex, dash2());
        tick(2);
        chk("t3_multi_hex2", b_hex, dash2());
        // valid load clears err, display static
        b_in = 26'd1; b_load = 1'b1;
        tick(1); b_load = 1'b0; tick(4);
        chk("t3_valid_hex", b_hex, {7'h40, 7'h79});
        chk("t3_valid_err", b_err, 1'b0);
        tick(5);
        chk("t3_static_hex", b_hex, {7'h40, 7'h79});

        // 4: single decimal digit, 10 overflows, 9 fits
        o_in = 26'd1 << 9; o_load = 1'b1;
        tick(1); o_load = 1'b0; tick(3);
        chk("t4_ovf_err", o_err, 1'b1);
        chk("t4_ovf_busy", o_busy, 1'b0);
        chk("t4_ovf_hex", o_hex, dash1());
        tick(3);
        chk("t4_ovf_hex2", o_hex, dash1());
        o_in = 26'd1 << 8; o_load = 1'b1;
        tick(1); o_load = 1'b0; tick(3);
        chk("t4_nine_hex", o_hex, 7'h18);
        chk("t4_nine_err", o_err, 1'b0);

        // 5: second load while busy is dropped
        d_in = 26'd1 << 4; d_load = 1'b1;
        tick(1);                       // edge k
        d_in = 26'd1 << 7;             // still loading at k+1
        tick(1);
        d_load = 1'b0;
        tick(3);                       // edge k+4
        chk("t5_first_hex", d_hex, {7'h40, 7'h12});
        chk("t5_busy", d_busy, 1'b0);
        tick(3);
        chk("t5_no_second", d_hex, {7'h40, 7'h12});
        chk("t5_busy_idle", d_busy, 1'b0);

        // 6: reset during CONV
        d_in = 26'd1 << 1; d_load = 1'b1;
        tick(1); d_load = 1'b0;
        tick(1);                       // now in CONV
        chk("t6_busy_pre", d_busy, 1'b1);
        reset_n = 1'b0;
        tick(1);
        chk("t6_rst_hex", d_hex, 14'h3FFF);
        chk("t6_rst_busy", d_busy, 1'b0);
        chk("t6_rst_err", d_err, 1'b0);
        chk("t6_rst_b_hex", b_hex, 14'h3FFF);
        reset_n = 1'b1;
        d_in = 26'd1 << 2; d_load = 1'b1;
        tick(1); d_load = 1'b0;
        tick(3);
        chk("t6_busy_k3", d_busy, 1'b1);
        chk("t6_no_partial", d_hex, 14'h3FFF);
        tick(1);
        chk("t6_hex", d_hex, {7'h40, 7'h30});
        chk("t6_busy_done", d_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
